// File: rtl/display_dynamic_pwm.sv
// Time-multiplexed 7-segment driver: per-digit dots, leading-zero blanking, PWM dimming, frame strobe.
// Latency: pins follow the scan tick by one clock; brightness reaches the digit pins one clock later.
// Backpressure: none; inputs are sampled at each slot tick and the scan free-runs while enabled.
//
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   enable           0 blanks all pins and parks the scan at digit 0
//   number, dots     one hex nibble and one decimal point per digit, digit 0 rightmost
//   blank_lz         suppress a-g of leading zero digits (digit 0 is never suppressed)
//   brightness       PWM duty; 0 = off, all-ones = always on
//   abcdefgh         segment pins (bit 7 = a ... bit 1 = g, bit 0 = h)
//   digit            digit select pins, bit i = digit i
//   frame_done       one-cycle pulse when the last digit has been loaded
module display_dynamic_pwm #(
  parameter int n_dig          = 4,
  parameter int refresh_w      = 16,
  parameter int dim_w          = 4,
  parameter bit seg_active_low = 1'b1,
  parameter bit dig_active_low = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [n_dig*4-1:0]   number,
  input  logic [n_dig-1:0]     dots,
  input  logic                 blank_lz,
  input  logic [dim_w-1:0]     brightness,
  output logic [7:0]           abcdefgh,
  output logic [n_dig-1:0]     digit,
  output logic                 frame_done
);

  localparam int              iw       = $clog2(n_dig);
  localparam logic [iw-1:0]   last_idx = iw'(n_dig - 1);

  // Logical a-g pattern, 1 = lit, bit 6 = a ... bit 0 = g.
  function automatic logic [6:0] seg7(input logic [3:0] h);
    logic [6:0] p;
    case (h)
      4'h0: p = 7'b1111110;
      4'h1: p = 7'b0110000;
      4'h2: p = 7'b1101101;
      4'h3: p = 7'b1111001;
      4'h4: p = 7'b0110011;
      4'h5: p = 7'b1011011;
      4'h6: p = 7'b1011111;
      4'h7: p = 7'b1110000;
      4'h8: p = 7'b1111111;
      4'h9: p = 7'b1111011;
      4'hA: p = 7'b1110111;
      4'hB: p = 7'b0011111;
      4'hC: p = 7'b1001110;
      4'hD: p = 7'b0111101;
      4'hE: p = 7'b1001111;
      default: p = 7'b1000111;
    endcase
    return p;
  endfunction

  logic [refresh_w-1:0] cnt;
  logic [iw-1:0]        idx;
  logic [7:0]           seg_l;     // segments of the digit being shown, 1 = lit
  logic [n_dig-1:0]     sel;       // one-hot digit being shown

  logic                 tick;
  logic                 on;
  logic                 lead_zero;
  logic [3:0]           nib;
  logic [7:0]           seg_nxt;
  logic [n_dig-1:0]     sel_nxt;
  logic [n_dig-1:0]     act_nxt;

  assign tick = enable && (cnt == '0);
  assign nib  = number[{idx, 2'b00} +: 4];

  // Shifting the current nibble down to bit 0 leaves only it and the more
  // significant ones; all zero means this digit is a leading zero.
  assign lead_zero = blank_lz && (idx != '0) && ((number >> {idx, 2'b00}) == '0);

  // Top bits of the slot counter form the PWM ramp, so the lit window sits
  // at the start of each slot.
  assign on = (cnt[refresh_w-1 -: dim_w] < brightness) || (brightness == '1);

  always_comb begin
    seg_nxt = seg_l;
    sel_nxt = sel;
    if (!enable) begin
      seg_nxt = '0;
      sel_nxt = '0;
    end else if (tick) begin
      seg_nxt      = {(lead_zero ? 7'b0000000 : seg7(nib)), dots[idx]};
      sel_nxt      = '0;
      sel_nxt[idx] = 1'b1;
    end
    // A fully dark digit is still scanned but its pin stays inactive.
    act_nxt = (on && (seg_nxt != 8'h00)) ? sel_nxt : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      idx        <= '0;
      seg_l      <= '0;
      sel        <= '0;
      abcdefgh   <= seg_active_low ? 8'hFF : 8'h00;
      digit      <= dig_active_low ? '1 : '0;
      frame_done <= 1'b0;
    end else begin
      seg_l      <= seg_nxt;
      sel        <= sel_nxt;
      abcdefgh   <= seg_active_low ? ~seg_nxt : seg_nxt;
      digit      <= dig_active_low ? ~act_nxt : act_nxt;
      frame_done <= tick && (idx == last_idx);
      if (!enable) begin
        cnt <= '0;
        idx <= '0;
      end else begin
        cnt <= cnt + refresh_w'(1);
        if (tick) begin
          idx <= (idx == last_idx) ? '0 : idx + iw'(1);
        end
      end
    end
  end

endmodule
